// File: rtl/password_pkg.sv
// Shared definitions for the parametrised password lock.
//   state_e   : controller state encoding (ENTRY, CHECK, OPEN, LOCKOUT)
//   SEG_BLANK : active-low pattern with every segment off
//   SEG_DASH  : active-low pattern with only the middle segment (g) on
package password_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/password_lock_param_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
//   value_i : 4-bit digit value 0-F
//   seg_o   : segments {g,f,e,d,c,b,a}, a segment is lit when its bit is 0
module hex7seg (
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (value_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/password_lock_param.sv
// Parametrised password-lock controller.
// Collects N_DIGITS digits, one per enter press, compares them with PASSWORD,
// opens an unlock window on a match and enforces a timed lockout after
// MAX_FAILS consecutive mismatches.
//   clk_i           : system clock
//   rst_ni          : asynchronous active-low reset
//   digit_in_i      : digit value from the switches
//   enter_i         : raw enter level (asynchronous)
//   clear_i         : raw clear level (asynchronous), discards a partial entry
//   unlocked_o      : high while the unlock window is open
//   locked_out_o    : high during lockout
//   fail_pulse_o    : one-cycle pulse per mismatch
//   attempts_left_o : MAX_FAILS minus consecutive fail count
//   digit_count_o   : digits captured so far
//   hex_out_o       : active-low segments, bits [6:0] show digit 0
module password_lock_param
  import password_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_W        = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0] PASSWORD = 16'h1234,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 150_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [DIGIT_W-1:0]                 digit_in_i,
  input  logic                               enter_i,
  input  logic                               clear_i,
  output logic                               unlocked_o,
  output logic                               locked_out_o,
  output logic                               fail_pulse_o,
  output logic [$clog2(MAX_FAILS+1)-1:0]     attempts_left_o,
  output logic [$clog2(N_DIGITS+1)-1:0]      digit_count_o,
  output logic [7*N_DIGITS-1:0]              hex_out_o
);

  localparam int CODE_W  = N_DIGITS * DIGIT_W;
  localparam int CNT_W   = $clog2(N_DIGITS + 1);
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int WIN_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int WIN_W   = $clog2(WIN_MAX + 1);

  // Synchroniser and one-shot state for the two asynchronous buttons
  logic [1:0] enterSync_q, clearSync_q;
  logic       enterPrev_q, clearPrev_q;
  logic       enterEvent, clearEvent;

  // Controller registers
  state_e              state_q, state_d;
  logic [CODE_W-1:0]   buffer_q, buffer_d;
  logic [CNT_W-1:0]    digitCount_q, digitCount_d;
  logic [FAIL_W-1:0]   failCount_q, failCount_d;
  logic [WIN_W-1:0]    window_q, window_d;
  logic                failPulse_d;

  // Registered outputs
  logic                  unlocked_q, lockedOut_q, failPulse_q;
  logic [FAIL_W-1:0]     attemptsLeft_q;
  logic [7*N_DIGITS-1:0] hex_q, hex_d;

  // Display decode
  logic [3:0] glyphIn [N_DIGITS];
  logic [6:0] glyph   [N_DIGITS];

  // Two-flop synchronisers followed by a rising-edge detector; the previous
  // value flop resets low so a level held through reset still gives one event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enterSync_q <= '0;
      clearSync_q <= '0;
      enterPrev_q <= 1'b0;
      clearPrev_q <= 1'b0;
    end else begin
      enterSync_q <= {enterSync_q[0], enter_i};
      clearSync_q <= {clearSync_q[0], clear_i};
      enterPrev_q <= enterSync_q[1];
      clearPrev_q <= clearSync_q[1];
    end
  end

  assign enterEvent = enterSync_q[1] & ~enterPrev_q;
  assign clearEvent = clearSync_q[1] & ~clearPrev_q;

  // Next-state logic. The mismatch pulse is decided at the capture of the
  // last digit so that the registered pulse lines up with the CHECK cycle.
  always_comb begin
    state_d      = state_q;
    buffer_d     = buffer_q;
    digitCount_d = digitCount_q;
    failCount_d  = failCount_q;
    window_d     = window_q;
    failPulse_d  = 1'b0;
    case (state_q)
      ENTRY: begin
        if (clearEvent) begin
          digitCount_d = '0;
          buffer_d     = '0;
        end else if (enterEvent) begin
          for (int p = 0; p < N_DIGITS; p++) begin
            if (CNT_W'(p) == digitCount_q) begin
              buffer_d[(N_DIGITS-1-p)*DIGIT_W +: DIGIT_W] = digit_in_i;
            end
          end
          digitCount_d = digitCount_q + 1'b1;
          if (digitCount_q == CNT_W'(N_DIGITS - 1)) begin
            state_d     = CHECK;
            failPulse_d = (buffer_d != PASSWORD);
          end
        end
      end
      CHECK: begin
        digitCount_d = '0;
        if (buffer_q == PASSWORD) begin
          failCount_d = '0;
          window_d    = WIN_W'(UNLOCK_CYCLES - 1);
          state_d     = OPEN;
        end else begin
          failCount_d = failCount_q + 1'b1;
          if (failCount_d == FAIL_W'(MAX_FAILS)) begin
            window_d = WIN_W'(LOCKOUT_CYCLES - 1);
            state_d  = LOCKOUT;
          end else begin
            state_d = ENTRY;
          end
        end
      end
      OPEN: begin
        if (window_q == '0) begin
          state_d = ENTRY;
        end else begin
          window_d = window_q - 1'b1;
        end
      end
      LOCKOUT: begin
        if (window_q == '0) begin
          state_d     = ENTRY;
          failCount_d = '0;
        end else begin
          window_d = window_q - 1'b1;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  // One decoder per display position; narrow digits are zero-extended.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    assign glyphIn[g] = 4'(buffer_q[(N_DIGITS-1-g)*DIGIT_W +: DIGIT_W]);
    hex7seg u_hex7seg (
      .value_i (glyphIn[g]),
      .seg_o   (glyph[g])
    );
  end

  // Display pattern chosen from the current state; it is registered, so it
  // tracks the unlocked/locked_out flags which are also one cycle behind state.
  always_comb begin
    hex_d = '0;
    for (int p = 0; p < N_DIGITS; p++) begin
      case (state_q)
        ENTRY:       hex_d[7*p +: 7] = (CNT_W'(p) < digitCount_q) ? glyph[p] : SEG_BLANK;
        CHECK, OPEN: hex_d[7*p +: 7] = glyph[p];
        LOCKOUT:     hex_d[7*p +: 7] = SEG_DASH;
        default:     hex_d[7*p +: 7] = SEG_BLANK;
      endcase
    end
  end

  // Controller state and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ENTRY;
      buffer_q       <= '0;
      digitCount_q   <= '0;
      failCount_q    <= '0;
      window_q       <= '0;
      unlocked_q     <= 1'b0;
      lockedOut_q    <= 1'b0;
      failPulse_q    <= 1'b0;
      attemptsLeft_q <= FAIL_W'(MAX_FAILS);
      hex_q          <= {N_DIGITS{SEG_BLANK}};
    end else begin
      state_q        <= state_d;
      buffer_q       <= buffer_d;
      digitCount_q   <= digitCount_d;
      failCount_q    <= failCount_d;
      window_q       <= window_d;
      unlocked_q     <= (state_q == OPEN);
      lockedOut_q    <= (state_q == LOCKOUT);
      failPulse_q    <= failPulse_d;
      attemptsLeft_q <= FAIL_W'(MAX_FAILS) - failCount_d;
      hex_q          <= hex_d;
    end
  end

  assign unlocked_o      = unlocked_q;
  assign locked_out_o    = lockedOut_q;
  assign fail_pulse_o    = failPulse_q;
  assign attempts_left_o = attemptsLeft_q;
  assign digit_count_o   = digitCount_q;
  assign hex_out_o       = hex_q;

endmodule

// File: tb/tb_password_lock_param.sv
// Self-checking bench for password_lock_param with a 4-digit 1234 code,
// MAX_FAILS=3, a 10-cycle unlock window and a 20-cycle lockout.
module tb_password_lock_param;

  localparam logic [27:0] ALL_BLANK = 28'hFFFFFFF;
  localparam logic [27:0] ALL_DASH  = {4{7'b0111111}};
  localparam logic [27:0] HEX_1234  = {7'h19, 7'h30, 7'h24, 7'h79};

  logic        clk;
  logic        rst_n;
  logic [3:0]  digitIn;
  logic        enter;
  logic        clear;
  logic        unlocked;
  logic        lockedOut;
  logic        failPulse;
  logic [1:0]  attemptsLeft;
  logic [2:0]  digitCount;
  logic [27:0] hexOut;

  int nApplied;
  int nMiscompares;

  // Statistics gathered while watching one code entry
  int          unlockCnt, firstUnlock;
  int          failCnt, firstFail;
  int          lockCnt, firstLock;
  logic [1:0]  attMid;
  logic [27:0] hexMid;

  typedef struct {
    logic [15:0] code;
    int          unlockCnt;
    int          failCnt;
    int          lockCnt;
    int          attMid;
    int          attEnd;
    logic [27:0] hexMid;
  } vec_t;

  vec_t vecs [7];

  password_lock_param #(
    .N_DIGITS       (4),
    .DIGIT_W        (4),
    .PASSWORD       (16'h1234),
    .MAX_FAILS      (3),
    .UNLOCK_CYCLES  (10),
    .LOCKOUT_CYCLES (20)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .digit_in_i      (digitIn),
    .enter_i         (enter),
    .clear_i         (clear),
    .unlocked_o      (unlocked),
    .locked_out_o    (lockedOut),
    .fail_pulse_o    (failPulse),
    .attempts_left_o (attemptsLeft),
    .digit_count_o   (digitCount),
    .hex_out_o       (hexOut)
  );

  // 100 MHz-style free-running clock; outputs are sampled on the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expected value and tally the result
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All outputs must sit at their reset values
  task automatic checkResetValues(input string tag);
    checkOutput({tag, " unlocked"}, 32'(unlocked), 32'd0);
    checkOutput({tag, " locked_out"}, 32'(lockedOut), 32'd0);
    checkOutput({tag, " fail_pulse"}, 32'(failPulse), 32'd0);
    checkOutput({tag, " attempts_left"}, 32'(attemptsLeft), 32'd3);
    checkOutput({tag, " digit_count"}, 32'(digitCount), 32'd0);
    checkOutput({tag, " hex_out"}, 32'(hexOut), 32'(ALL_BLANK));
  endtask

  // One enter press: 3 cycles high, 3 cycles low
  task automatic applyStimulus(input logic [3:0] d);
    digitIn = d;
    enter   = 1'b1;
    repeat (3) @(negedge clk);
    enter   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Enter a full code and watch the outputs for nCycles falling edges after
  // the last press begins. Cycle i is the i-th falling edge after enter rises.
  task automatic runCode(input logic [15:0] code, input int nCycles);
    applyStimulus(code[15:12]);
    applyStimulus(code[11:8]);
    applyStimulus(code[7:4]);
    digitIn = code[3:0];
    enter   = 1'b1;
    unlockCnt = 0; firstUnlock = 0;
    failCnt   = 0; firstFail   = 0;
    lockCnt   = 0; firstLock   = 0;
    attMid    = 2'd0;
    hexMid    = '0;
    for (int i = 1; i <= nCycles; i++) begin
      @(negedge clk);
      if (i == 3) enter = 1'b0;
      if (unlocked) begin
        unlockCnt++;
        if (firstUnlock == 0) firstUnlock = i;
      end
      if (failPulse) begin
        failCnt++;
        if (firstFail == 0) firstFail = i;
      end
      if (lockedOut) begin
        lockCnt++;
        if (firstLock == 0) firstLock = i;
      end
      if (i == 5) begin
        attMid = attemptsLeft;
        hexMid = hexOut;
      end
    end
  endtask

  initial begin
    nApplied     = 0;
    nMiscompares = 0;
    rst_n   = 1'b0;
    digitIn = 4'h0;
    enter   = 1'b0;
    clear   = 1'b0;

    // Vector table: code, unlock cycles, fail pulses, lockout cycles,
    // attempts_left at cycle 5, attempts_left at the end, display at cycle 5
    vecs[0] = '{16'h1234, 10, 0, 0,  3, 3, HEX_1234};
    vecs[1] = '{16'h1235,  0, 1, 0,  2, 2, ALL_BLANK};
    vecs[2] = '{16'h1234, 10, 0, 0,  3, 3, HEX_1234};
    vecs[3] = '{16'h0000,  0, 1, 0,  2, 2, ALL_BLANK};
    vecs[4] = '{16'hABCD,  0, 1, 0,  1, 1, ALL_BLANK};
    vecs[5] = '{16'h4321,  0, 1, 20, 0, 3, ALL_DASH};
    vecs[6] = '{16'h1234, 10, 0, 0,  3, 3, HEX_1234};

    // Reset state while reset is held
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven code entries; each is followed by 40 cycles of observation
    $display("[TB] applying %0d code vectors", 7);
    for (int v = 0; v < 7; v++) begin
      runCode(vecs[v].code, 40);
      checkOutput($sformatf("v%0d unlock_cycles", v), 32'(unlockCnt), 32'(vecs[v].unlockCnt));
      checkOutput($sformatf("v%0d unlock_start", v), 32'(firstUnlock), (vecs[v].unlockCnt != 0) ? 32'd5 : 32'd0);
      checkOutput($sformatf("v%0d fail_pulses", v), 32'(failCnt), 32'(vecs[v].failCnt));
      checkOutput($sformatf("v%0d fail_cycle", v), 32'(firstFail), (vecs[v].failCnt != 0) ? 32'd3 : 32'd0);
      checkOutput($sformatf("v%0d lock_cycles", v), 32'(lockCnt), 32'(vecs[v].lockCnt));
      checkOutput($sformatf("v%0d lock_start", v), 32'(firstLock), (vecs[v].lockCnt != 0) ? 32'd5 : 32'd0);
      checkOutput($sformatf("v%0d attempts_mid", v), 32'(attMid), 32'(vecs[v].attMid));
      checkOutput($sformatf("v%0d hex_mid", v), 32'(hexMid), 32'(vecs[v].hexMid));
      checkOutput($sformatf("v%0d attempts_end", v), 32'(attemptsLeft), 32'(vecs[v].attEnd));
      checkOutput($sformatf("v%0d count_end", v), 32'(digitCount), 32'd0);
      checkOutput($sformatf("v%0d hex_end", v), 32'(hexOut), 32'(ALL_BLANK));
    end

    // Enter presses during lockout must be ignored
    $display("[TB] lockout with ignored presses");
    runCode(16'h1111, 40);
    runCode(16'h2222, 40);
    runCode(16'h3333, 6);
    checkOutput("lock active", 32'(lockedOut), 32'd1);
    applyStimulus(4'h9);
    applyStimulus(4'h9);
    applyStimulus(4'h9);
    checkOutput("lock count_ignored", 32'(digitCount), 32'd0);
    checkOutput("lock hex_dash", 32'(hexOut), 32'(ALL_DASH));
    repeat (20) @(negedge clk);
    checkOutput("lock released", 32'(lockedOut), 32'd0);
    checkOutput("lock attempts_restored", 32'(attemptsLeft), 32'd3);
    checkOutput("lock count_after", 32'(digitCount), 32'd0);
    runCode(16'h1234, 40);
    checkOutput("post_lock unlock_cycles", 32'(unlockCnt), 32'd10);

    // Partial entry then clear
    $display("[TB] clear handling");
    applyStimulus(4'h1);
    applyStimulus(4'h2);
    checkOutput("partial count", 32'(digitCount), 32'd2);
    checkOutput("partial hex", 32'(hexOut), 32'({7'h7F, 7'h7F, 7'h24, 7'h79}));
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("clear count", 32'(digitCount), 32'd0);
    checkOutput("clear hex", 32'(hexOut), 32'(ALL_BLANK));

    // Clear and enter rising together: the clear must win
    applyStimulus(4'h1);
    digitIn = 4'h7;
    enter   = 1'b1;
    clear   = 1'b1;
    repeat (3) @(negedge clk);
    enter   = 1'b0;
    clear   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("simul count", 32'(digitCount), 32'd0);
    checkOutput("simul hex", 32'(hexOut), 32'(ALL_BLANK));

    // Enter held for 50 cycles gives exactly one capture
    $display("[TB] held enter");
    digitIn = 4'h5;
    enter   = 1'b1;
    repeat (50) @(negedge clk);
    enter   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("held count", 32'(digitCount), 32'd1);
    checkOutput("held hex", 32'(hexOut), 32'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);

    // Reset pulse during the unlock window
    $display("[TB] reset mid-operation");
    runCode(16'h1234, 7);
    checkOutput("open before_reset", 32'(unlocked), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues("rst_open");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset pulse in the middle of a lockout
    runCode(16'h9999, 40);
    runCode(16'h9998, 40);
    runCode(16'h9997, 10);
    checkOutput("lock before_reset", 32'(lockedOut), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues("rst_lock");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal unlock after the resets
    runCode(16'h1234, 40);
    checkOutput("post_reset unlock_cycles", 32'(unlockCnt), 32'd10);
    checkOutput("post_reset unlock_start", 32'(firstUnlock), 32'd5);
    checkOutput("post_reset fail_pulses", 32'(failCnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
